// File: rtl/ccd_word_packer.sv
// Packs the CCD grayscale pixel stream into 16*LANES-bit words, one frame of WORDS words per start.
// Optional build macro PACKER_INVERT_EN stores inverted pixels (white-on-black).
module ccd_word_packer #(
   parameter int PIX_W  = 12,
   parameter int LANES  = 16,
   parameter int WORDS  = 49,
   parameter int ADDR_W = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  sof,
   input  logic                  pix_val,
   input  logic [PIX_W-1:0]      pix_data,
   output logic                  dmem_wren,
   output logic [ADDR_W-1:0]     dmem_wraddr,
   output logic [16*LANES-1:0]   dmem_wrdata,
   output logic                  busy,
   output logic                  done,
   output logic                  sof_err
);
   localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PACK, S_DONE} state_t;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       lane_cnt, lane_idx;
   logic [ADDR_W-1:0]      addr, addr_cur;
   logic [LANES-1:0][15:0] asm_q, word_nxt;
   logic [15:0]            lane_val;
   logic                   take, rewind, finish, sof_hit, word_full, wr_last;

`ifdef PACKER_INVERT_EN
   assign lane_val = {{(16-PIX_W){1'b0}}, ~pix_data};
`else
   assign lane_val = {{(16-PIX_W){1'b0}}, pix_data};
`endif

   assign busy = (state == S_ARMED) || (state == S_PACK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      rewind    = 1'b0;
      finish    = 1'b0;
      sof_hit   = 1'b0;
      if (start) begin
         state_nxt = S_ARMED;
         rewind    = 1'b1;
      end else begin
         case (state)
            S_ARMED: if (sof) begin
               state_nxt = S_PACK;
               rewind    = 1'b1;
               take      = pix_val;
            end
            // the final write cycle closes the frame; pixels and sof in it are dropped
            S_PACK: if (dmem_wren && wr_last) begin
               state_nxt = S_DONE;
               finish    = 1'b1;
            end else begin
               take = pix_val;
               if (sof) begin
                  rewind  = 1'b1;
                  sof_hit = (lane_cnt != '0) || (addr != '0);
               end
            end
            default: ;
         endcase
      end
      lane_idx           = rewind ? '0 : lane_cnt;
      addr_cur           = rewind ? '0 : addr;
      word_full          = take && (lane_idx == CNT_W'(LANES-1));
      word_nxt           = asm_q;
      word_nxt[lane_idx] = lane_val;
   end

   // Completed words move to the output register, so the assembly buffer is free the next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_cnt    <= '0;
         addr        <= '0;
         asm_q       <= '0;
         wr_last     <= 1'b0;
         dmem_wren   <= 1'b0;
         dmem_wraddr <= '0;
         dmem_wrdata <= '0;
         done        <= 1'b0;
         sof_err     <= 1'b0;
      end else begin
         dmem_wren <= 1'b0;
         if (start) begin
            done    <= 1'b0;
            sof_err <= 1'b0;
         end
         if (finish)  done    <= 1'b1;
         if (sof_hit) sof_err <= 1'b1;
         if (rewind) begin
            lane_cnt <= '0;
            addr     <= '0;
         end
         if (take) begin
            asm_q[lane_idx] <= lane_val;
            if (word_full) begin
               dmem_wren   <= 1'b1;
               dmem_wraddr <= addr_cur;
               dmem_wrdata <= word_nxt;
               lane_cnt    <= '0;
               wr_last     <= (addr_cur == ADDR_W'(WORDS-1));
               addr        <= (addr_cur == ADDR_W'(WORDS-1)) ? addr_cur : addr_cur + 1'b1;
            end else begin
               lane_cnt <= lane_idx + 1'b1;
            end
         end
      end
   end
endmodule
